// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM stage: opcode classes, bus FSM states, M-register layout.
package memory_stage_pkg;

   localparam logic [31:0] MEM_ADDR_MASK = 32'hFFFF_FFFC;

   localparam logic [5:0] IC_NOP = 6'd0;
   localparam logic [5:0] IC_ADD = 6'd1;
   localparam logic [5:0] IC_SPE = 6'd2;
   localparam logic [5:0] IC_BEQ = 6'd3;
   localparam logic [5:0] IC_LW  = 6'd4;
   localparam logic [5:0] IC_SW  = 6'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [5:0]  icode;
      logic [5:0]  acode;
      logic [31:0] val;
      logic [31:0] val2;
      logic [4:0]  dst;
   } m_regs_t;

   function automatic logic is_mem_op(input logic [5:0] icode);
      return (icode == IC_LW) || (icode == IC_SW);
   endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-bus interface between the MEM stage (master) and the data memory (slave).
interface memory_stage_if;
   // dreq_valid holds with addr/data/strobe/write stable until dresp_addr_ok is seen;
   // dresp_data_ok then ends the transaction and may coincide with dresp_addr_ok.
   logic        dreq_valid;
   logic        dreq_write;
   logic [31:0] dreq_addr;
   logic [3:0]  dreq_strobe;
   logic [31:0] dreq_data;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [31:0] dresp_data;

   modport master (
      output dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
      input  dresp_addr_ok, dresp_data_ok, dresp_data
   );

   modport slave (
      input  dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
      output dresp_addr_ok, dresp_data_ok, dresp_data
   );
endinterface

// File: rtl/memory_stage_mem_bus_fsm.sv
// Data-bus handshake FSM: drives dreq_*, tracks REQ/WAIT and pulses completion.
module memory_stage_mem_bus_fsm
   import memory_stage_pkg::*;
(
   input  logic          clk,
   input  logic          resetn,
   input  logic          mem_op_i,
   input  logic          write_i,
   input  logic [31:0]   addr_i,
   input  logic [31:0]   wdata_i,
   memory_stage_if.master bus,
   output logic          complete_o,
   output mem_state_t    state_o
);

   mem_state_t state_q, state_d;
   logic       in_req;

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // A mem op arriving in IDLE is treated as REQ in the same cycle, so the bus sees it at once.
   always_comb begin
      state_d        = IDLE;
      in_req         = 1'b0;
      complete_o     = 1'b0;
      bus.dreq_valid = 1'b0;
      unique case (state_q)
         IDLE, REQ: in_req = mem_op_i;
         WAIT: begin
            if (bus.dresp_data_ok) complete_o = 1'b1;
            else                   state_d    = WAIT;
         end
         default: state_d = IDLE;
      endcase
      if (in_req) begin
         bus.dreq_valid = 1'b1;
         if (bus.dresp_addr_ok && bus.dresp_data_ok) complete_o = 1'b1;
         else if (bus.dresp_addr_ok)                 state_d    = WAIT;
         else                                        state_d    = REQ;
      end
   end

   assign bus.dreq_write  = write_i;
   assign bus.dreq_addr   = addr_i;
   assign bus.dreq_strobe = {4{write_i}};
   assign bus.dreq_data   = wdata_i;
   assign state_o         = state_q;

endmodule

// File: rtl/memory_stage.sv
// MEM stage: M pipeline register, data-bus access for LW/SW and the W_* output mux.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter logic [31:0] ADDR_MASK   = MEM_ADDR_MASK,
   parameter logic [5:0]  BUBBLE_CODE = IC_NOP
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          E_valid,
   input  logic [31:0]   E_pc,
   input  logic [5:0]    E_icode,
   input  logic [5:0]    E_acode,
   input  logic [31:0]   E_val,
   input  logic [31:0]   E_val2,
   input  logic [4:0]    E_dst,
   output logic          m_stall,
   memory_stage_if.master bus,
   output logic [31:0]   W_pc,
   output logic [5:0]    W_icode,
   output logic [5:0]    W_acode,
   output logic [31:0]   W_val3,
   output logic [4:0]    W_dst,
   output mem_state_t    dbg_state_o
);

   m_regs_t m_q, m_d;
   logic    mem_op;
   logic    complete;

   assign mem_op  = m_q.valid && is_mem_op(m_q.icode);
   assign m_stall = mem_op && !complete;

   always_comb begin
      m_d = m_q;
      if (!m_stall) begin
         m_d = '0;
         if (E_valid) begin
            m_d.valid = 1'b1;
            m_d.pc    = E_pc;
            m_d.icode = E_icode;
            m_d.acode = E_acode;
            m_d.val   = E_val;
            m_d.val2  = E_val2;
            m_d.dst   = E_dst;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) m_q <= '0;
      else         m_q <= m_d;
   end

   memory_stage_mem_bus_fsm u_bus_fsm (
      .clk        (clk),
      .resetn     (resetn),
      .mem_op_i   (mem_op),
      .write_i    (m_q.icode == IC_SW),
      .addr_i     (m_q.val & ADDR_MASK),
      .wdata_i    (m_q.val2),
      .bus        (bus),
      .complete_o (complete),
      .state_o    (dbg_state_o)
   );

   // While stalled, W shows a bubble so each instruction reaches writeback exactly once.
   always_comb begin
      W_pc    = '0;
      W_icode = BUBBLE_CODE;
      W_acode = '0;
      W_dst   = '0;
      W_val3  = '0;
      if (m_q.valid && !m_stall) begin
         W_pc    = m_q.pc;
         W_icode = m_q.icode;
         W_acode = m_q.acode;
         W_dst   = m_q.dst;
         W_val3  = (m_q.icode == IC_LW) ? bus.dresp_data : m_q.val;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: op-level model with a bus responder and W-output scoreboard.
module tb_memory_stage;
   import memory_stage_pkg::*;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [5:0]  icode;
      logic [5:0]  acode;
      logic [31:0] val;
      logic [31:0] val2;
      logic [4:0]  dst;
      logic [7:0]  a;      // cycles of request before addr_ok
      logic [7:0]  d;      // further cycles until data_ok
      logic [31:0] rdata;
   } op_t;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        E_valid;
   logic [31:0] E_pc, E_val, E_val2;
   logic [5:0]  E_icode, E_acode;
   logic [4:0]  E_dst;
   logic        m_stall;
   logic [31:0] W_pc, W_val3;
   logic [5:0]  W_icode, W_acode;
   logic [4:0]  W_dst;
   mem_state_t  dbg_state;

   always #5 clk = ~clk;

   memory_stage_if bus ();

   memory_stage dut (
      .clk         (clk),
      .resetn      (resetn),
      .E_valid     (E_valid),
      .E_pc        (E_pc),
      .E_icode     (E_icode),
      .E_acode     (E_acode),
      .E_val       (E_val),
      .E_val2      (E_val2),
      .E_dst       (E_dst),
      .m_stall     (m_stall),
      .bus         (bus),
      .W_pc        (W_pc),
      .W_icode     (W_icode),
      .W_acode     (W_acode),
      .W_val3      (W_val3),
      .W_dst       (W_dst),
      .dbg_state_o (dbg_state)
   );

   // ---------------- model state ----------------
   op_t         ops[$];
   op_t         cur;
   bit          busy, m_valid_m, stall_m, stray, chk_en, exp_dv;
   int          cyc;
   logic [80:0] exp_q[$];
   int          n_checks, n_fail, stall_cnt, w_cnt;

   task automatic check(input string name, input logic [80:0] act, input logic [80:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic op_t mk(input logic [31:0] pc, input logic [5:0] ic, input logic [5:0] ac,
                              input logic [31:0] val, input logic [31:0] val2, input logic [4:0] dst,
                              input int a, input int d, input logic [31:0] rdata);
      op_t o;
      o.valid = 1'b1; o.pc = pc; o.icode = ic; o.acode = ac; o.val = val; o.val2 = val2;
      o.dst = dst; o.a = 8'(a); o.d = 8'(d); o.rdata = rdata;
      return o;
   endfunction

   function automatic logic [80:0] w_of(input op_t o);
      return {o.pc, o.icode, o.acode, o.dst, (o.icode == IC_LW) ? o.rdata : o.val};
   endfunction

   function automatic int done_cyc();
      return int'(cur.a) + int'(cur.d);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_e();
      op_t o;
      o = (ops.size() > 0) ? ops[0] : op_t'(0);
      E_valid = o.valid; E_pc = o.pc; E_icode = o.icode; E_acode = o.acode;
      E_val = o.val; E_val2 = o.val2; E_dst = o.dst;
   endtask

   task automatic drive_bus();
      bit fin;
      fin = busy && (cyc == done_cyc());
      bus.dresp_addr_ok = busy && (cyc == int'(cur.a));
      bus.dresp_data_ok = fin || stray;
      bus.dresp_data    = fin ? cur.rdata : 32'h0BAD_F00D;
   endtask

   // One clock: update the model at the edge, then drive new inputs just after it.
   task automatic tick();
      op_t o;
      @(posedge clk);
      if (!resetn) begin
         if (m_valid_m && stall_m && exp_q.size() > 0) exp_q.pop_back();
         m_valid_m = 1'b0; busy = 1'b0; cyc = 0;
      end else begin
         if (busy) begin
            if (cyc == done_cyc()) busy = 1'b0;
            else cyc++;
         end
         if (!stall_m) begin
            o = (ops.size() > 0) ? ops[0] : op_t'(0);
            m_valid_m = o.valid;
            if (o.valid) exp_q.push_back(w_of(o));
            if (o.valid && (o.icode == IC_LW || o.icode == IC_SW)) begin
               busy = 1'b1; cyc = 0; cur = o;
            end
            if (ops.size() > 0) void'(ops.pop_front());
         end
      end
      stall_m = busy && (cyc != done_cyc());
      #1;
      drive_e();
      drive_bus();
   endtask

   task automatic run_until_idle(input int max_cycles);
      int n;
      n = 0;
      while ((ops.size() != 0 || busy || m_valid_m) && n < max_cycles) begin
         tick();
         n++;
      end
      check("drain", (ops.size() == 0 && !busy && !m_valid_m), 1);
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_stall", m_stall, stall_m);
         exp_dv = busy && (cyc <= int'(cur.a));
         check("dreq_valid", bus.dreq_valid, exp_dv);
         if (exp_dv) begin
            check("dreq_addr", bus.dreq_addr, cur.val & 32'hFFFF_FFFC);
            check("dreq_write", bus.dreq_write, cur.icode == IC_SW);
            check("dreq_strobe", bus.dreq_strobe, (cur.icode == IC_SW) ? 4'hF : 4'h0);
            if (cur.icode == IC_SW) check("dreq_data", bus.dreq_data, cur.val2);
         end
         if (m_valid_m && !stall_m) begin
            if (exp_q.size() == 0) check("w_unexpected", 1, 0);
            else check("w_out", {W_pc, W_icode, W_acode, W_dst, W_val3}, exp_q.pop_front());
         end else begin
            check("w_bubble", {W_pc, W_icode, W_acode, W_dst, W_val3}, 81'd0);
         end
         if (m_stall === 1'b1) stall_cnt++;
         if (W_icode !== IC_NOP) w_cnt++;
      end
   end

   // ---------------- directed scenarios ----------------
   int s0, w0;

   initial begin
      stray = 1'b0;
      drive_e();
      drive_bus();
      repeat (3) tick();
      resetn = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_state", dbg_state, IDLE);
      check("rst_stall", m_stall, 0);
      check("rst_dreq_valid", bus.dreq_valid, 0);
      check("rst_w_icode", W_icode, IC_NOP);

      // ADD passes straight through
      ops.push_back(mk(32'h100, IC_ADD, 6'd0, 32'h5, 32'h0, 5'd3, 0, 0, 32'h0));
      drive_e();
      tick();
      @(negedge clk);
      check("add_icode", W_icode, IC_ADD);
      check("add_val3", W_val3, 32'h5);
      check("add_dst", W_dst, 5'd3);
      check("add_stall", m_stall, 0);
      run_until_idle(10);

      // LW with addr_ok and data_ok together: no stall
      s0 = stall_cnt;
      ops.push_back(mk(32'h104, IC_LW, 6'd0, 32'h1003, 32'h0, 5'd7, 0, 0, 32'hDEAD_BEEF));
      drive_e();
      tick();
      @(negedge clk);
      check("lw_addr", bus.dreq_addr, 32'h1000);
      check("lw_val3", W_val3, 32'hDEAD_BEEF);
      check("lw_icode", W_icode, IC_LW);
      run_until_idle(10);
      check("lw_stall_cycles", stall_cnt - s0, 0);

      // SW with addr_ok after 2 cycles, data_ok 3 later
      s0 = stall_cnt; w0 = w_cnt;
      ops.push_back(mk(32'h108, IC_SW, 6'd0, 32'h20, 32'h55, 5'd0, 2, 3, 32'h0));
      drive_e();
      tick();
      @(negedge clk);
      check("sw_strobe", bus.dreq_strobe, 4'hF);
      check("sw_write", bus.dreq_write, 1);
      check("sw_w_bubble", W_icode, IC_NOP);
      run_until_idle(20);
      check("sw_stall_cycles", stall_cnt - s0, 5);
      check("sw_w_count", w_cnt - w0, 1);

      // back-to-back LWs
      s0 = stall_cnt; w0 = w_cnt;
      ops.push_back(mk(32'h10C, IC_LW, 6'd0, 32'h40, 32'h0, 5'd4, 0, 1, 32'h1111_1111));
      ops.push_back(mk(32'h110, IC_LW, 6'd0, 32'h44, 32'h0, 5'd5, 1, 0, 32'h2222_2222));
      drive_e();
      run_until_idle(20);
      check("lwlw_stall_cycles", stall_cnt - s0, 2);
      check("lwlw_w_count", w_cnt - w0, 2);

      // mixed stream
      s0 = stall_cnt; w0 = w_cnt;
      ops.push_back(mk(32'h114, IC_SPE, 6'h20, 32'h7, 32'h0, 5'd9, 0, 0, 32'h0));
      ops.push_back(mk(32'h118, IC_SW, 6'd0, 32'h30, 32'hA5A5, 5'd0, 1, 1, 32'h0));
      ops.push_back(mk(32'h11C, IC_ADD, 6'd0, 32'h123, 32'h0, 5'd2, 0, 0, 32'h0));
      ops.push_back(mk(32'h120, IC_LW, 6'd0, 32'h36, 32'h0, 5'd6, 0, 2, 32'hCAFE_F00D));
      drive_e();
      run_until_idle(30);
      check("mix_stall_cycles", stall_cnt - s0, 4);
      check("mix_w_count", w_cnt - w0, 4);

      // reset while waiting for data_ok, then a stray data_ok
      w0 = w_cnt;
      ops.push_back(mk(32'h124, IC_SW, 6'd0, 32'h50, 32'h77, 5'd0, 0, 20, 32'h0));
      drive_e();
      tick();
      tick();
      @(negedge clk);
      check("wait_state", dbg_state, WAIT);
      tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      stray  = 1'b1;
      drive_bus();
      @(negedge clk);
      check("abort_state", dbg_state, IDLE);
      check("abort_dreq_valid", bus.dreq_valid, 0);
      tick();
      stray = 1'b0;
      drive_bus();
      @(negedge clk);
      check("stray_state", dbg_state, IDLE);
      check("stray_dreq_valid", bus.dreq_valid, 0);
      repeat (2) tick();
      check("abort_w_count", w_cnt - w0, 0);

      // three bubbles
      repeat (3) ops.push_back(op_t'(0));
      drive_e();
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         check("bubble_icode", W_icode, IC_NOP);
         check("bubble_dst", W_dst, 5'd0);
      end
      run_until_idle(10);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
